// File: rtl/adder_operand_stage.sv
// Handshake stage around the combinational 6-bit prefix adder.
// Holds operands stable for the adder, registers its result, keeps stats.
module adder_operand_stage #(
  parameter int W     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  input  logic [W-1:0]     add_s,
  input  logic             add_ov,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic             out_ov,
  output logic             ov_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ov_count,
  input  logic             clr_stats
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [W-1:0]     r_s;
  logic             r_ov;
  logic             r_sticky;
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_ov_cnt;

  logic w_idle;
  logic w_exec;
  logic w_hold;
  logic w_accept;
  logic w_op_max;
  logic w_ov_max;

  assign w_idle   = (r_state == IDLE);
  assign w_exec   = (r_state == EXEC);
  assign w_hold   = (r_state == HOLD);
  assign w_op_max = (r_op_cnt == {CNT_W{1'b1}});
  assign w_ov_max = (r_ov_cnt == {CNT_W{1'b1}});

  // Ready passes straight through from downstream while a result waits.
  assign in_ready = w_idle | (w_hold & out_ready);
  assign w_accept = in_valid & in_ready;

  assign out_valid = w_hold;
  assign add_x     = r_x;
  assign add_y     = r_y;
  assign out_s     = r_s;
  assign out_ov    = r_ov;
  assign ov_sticky = r_sticky;
  assign op_count  = r_op_cnt;
  assign ov_count  = r_ov_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_s      <= '0;
      r_ov     <= 1'b0;
      r_sticky <= 1'b0;
      r_op_cnt <= '0;
      r_ov_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_x <= in_x;
        r_y <= in_y;
      end

      unique case (r_state)
        IDLE: begin
          if (in_valid)
            r_state <= EXEC;
        end
        EXEC: begin
          r_s     <= add_s;
          r_ov    <= add_ov;
          r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready)
            r_state <= in_valid ? EXEC : IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A clear drops the statistics of a coincident capture.
      if (clr_stats) begin
        r_sticky <= 1'b0;
        r_op_cnt <= '0;
        r_ov_cnt <= '0;
      end else if (w_exec) begin
        if (!w_op_max)
          r_op_cnt <= r_op_cnt + CNT_W'(1);
        if (add_ov) begin
          r_sticky <= 1'b1;
          if (!w_ov_max)
            r_ov_cnt <= r_ov_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_stage.sv
// Directed bench for adder_operand_stage with a behavioural 6-bit adder
// attached to add_x/add_y/add_s/add_ov (ov = unsigned carry out).
module tb_adder_operand_stage;

  localparam int W     = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic [W-1:0]     add_x;
  logic [W-1:0]     add_y;
  logic [W-1:0]     add_s;
  logic             add_ov;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_s;
  logic             out_ov;
  logic             ov_sticky;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] ov_count;
  logic             clr_stats;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {add_ov, add_s} = {1'b0, add_x} + {1'b0, add_y};

  adder_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_s     (add_s),
    .add_ov    (add_ov),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_ov    (out_ov),
    .ov_sticky (ov_sticky),
    .op_count  (op_count),
    .ov_count  (ov_count),
    .clr_stats (clr_stats)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full IDLE -> EXEC -> HOLD -> IDLE operation, no checks.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; in_x = x; in_y = y; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b0; clr_stats = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (add_x !== 6'd0 || add_y !== 6'd0) begin n_err++; $display("FAIL rst_add got %0d/%0d exp 0/0", add_x, add_y); end
    n_cmp++; if (out_s !== 6'd0 || out_ov !== 1'b0) begin n_err++; $display("FAIL rst_out got %0d/%0b exp 0/0", out_s, out_ov); end
    n_cmp++; if (op_count !== 8'd0 || ov_count !== 8'd0 || ov_sticky !== 1'b0) begin n_err++; $display("FAIL rst_stats got %0d/%0d/%0b exp 0/0/0", op_count, ov_count, ov_sticky); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_x = 6'd3; in_y = 6'd5;
    tick();
    in_valid = 1'b0; in_x = 6'd0; in_y = 6'd0;
    n_cmp++; if (add_x !== 6'd3 || add_y !== 6'd5) begin n_err++; $display("FAIL basic_add got %0d/%0d exp 3/5", add_x, add_y); end
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_exec got rdy=%0b vld=%0b exp 0/0", in_ready, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
    n_cmp++; if (out_s !== 6'd8 || out_ov !== 1'b0) begin n_err++; $display("FAIL basic_sum got %0d/%0b exp 8/0", out_s, out_ov); end
    n_cmp++; if (op_count !== 8'd1 || ov_count !== 8'd0) begin n_err++; $display("FAIL basic_cnt got %0d/%0d exp 1/0", op_count, ov_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_passrdy got %0b exp 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1; in_valid = 1'b1; in_x = 6'd40; in_y = 6'd30;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_s !== 6'd6 || out_ov !== 1'b1) begin n_err++; $display("FAIL ov_sum got %0d/%0b exp 6/1", out_s, out_ov); end
    n_cmp++; if (ov_sticky !== 1'b1 || ov_count !== 8'd1 || op_count !== 8'd2) begin n_err++; $display("FAIL ov_stats got %0b/%0d/%0d exp 1/1/2", ov_sticky, ov_count, op_count); end
    tick();
    in_valid = 1'b1; in_x = 6'd1; in_y = 6'd1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_s !== 6'd2 || out_ov !== 1'b0) begin n_err++; $display("FAIL ov_next got %0d/%0b exp 2/0", out_s, out_ov); end
    n_cmp++; if (ov_sticky !== 1'b1 || ov_count !== 8'd1 || op_count !== 8'd3) begin n_err++; $display("FAIL ov_keep got %0b/%0d/%0d exp 1/1/3", ov_sticky, ov_count, op_count); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_x = 6'd10; in_y = 6'd20;
    tick();
    in_x = 6'd7; in_y = 6'd9;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs c%0d got vld=%0b rdy=%0b exp 1/0", c, out_valid, in_ready); end
      n_cmp++; if (out_s !== 6'd30 || out_ov !== 1'b0) begin n_err++; $display("FAIL bp_out c%0d got %0d/%0b exp 30/0", c, out_s, out_ov); end
      n_cmp++; if (add_x !== 6'd10 || add_y !== 6'd20) begin n_err++; $display("FAIL bp_ops c%0d got %0d/%0d exp 10/20", c, add_x, add_y); end
      n_cmp++; if (op_count !== 8'd4) begin n_err++; $display("FAIL bp_cnt c%0d got %0d exp 4", c, op_count); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %0b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (add_x !== 6'd7 || add_y !== 6'd9 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept got %0d/%0d vld=%0b exp 7/9/0", add_x, add_y, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 6'd16 || op_count !== 8'd5) begin n_err++; $display("FAIL bp_next got vld=%0b s=%0d cnt=%0d exp 1/16/5", out_valid, out_s, op_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tx [10] = '{6'd1, 6'd10, 6'd63, 6'd32, 6'd15, 6'd50, 6'd63, 6'd0, 6'd33, 6'd7};
    logic [W-1:0] ty [10] = '{6'd2, 6'd20, 6'd1,  6'd32, 6'd15, 6'd13, 6'd63, 6'd0, 6'd40, 6'd8};
    logic [W-1:0] es [10] = '{6'd3, 6'd30, 6'd0,  6'd0,  6'd30, 6'd63, 6'd62, 6'd0, 6'd9,  6'd15};
    logic         eo [10] = '{1'b0, 1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0, 1'b1,  1'b0};
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    n_cmp++; if (op_count !== 8'd0 || ov_count !== 8'd0 || ov_sticky !== 1'b0) begin n_err++; $display("FAIL b2b_clr got %0d/%0d/%0b exp 0/0/0", op_count, ov_count, ov_sticky); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_x = tx[k]; in_y = ty[k];
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_exec k%0d got vld=%0b exp 0", k, out_valid); end
      if (k == 9) in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_s !== es[k] || out_ov !== eo[k]) begin n_err++; $display("FAIL b2b_res k%0d got vld=%0b s=%0d ov=%0b exp 1/%0d/%0b", k, out_valid, out_s, out_ov, es[k], eo[k]); end
    end
    n_cmp++; if (op_count !== 8'd10 || ov_count !== 8'd4 || ov_sticky !== 1'b1) begin n_err++; $display("FAIL b2b_stats got %0d/%0d/%0b exp 10/4/1", op_count, ov_count, ov_sticky); end
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_valid = 1'b1; in_x = 6'd63; in_y = 6'd63;
    for (int c = 0; c < 600; c++) tick();
    in_valid = 1'b0;
    n_cmp++; if (op_count !== 8'd255 || ov_count !== 8'd255) begin n_err++; $display("FAIL sat_cnt got %0d/%0d exp 255/255", op_count, ov_count); end
    in_valid = 1'b1; in_x = 6'd5; in_y = 6'd6;
    tick();
    in_valid = 1'b0; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    n_cmp++; if (op_count !== 8'd0 || ov_count !== 8'd0 || ov_sticky !== 1'b0) begin n_err++; $display("FAIL sat_clr got %0d/%0d/%0b exp 0/0/0", op_count, ov_count, ov_sticky); end
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 6'd11 || out_ov !== 1'b0) begin n_err++; $display("FAIL sat_out got vld=%0b s=%0d ov=%0b exp 1/11/0", out_valid, out_s, out_ov); end
    tick();
  endtask

  task automatic test_reset_mid();
    run_op(6'd1, 6'd1);
    in_valid = 1'b1; in_x = 6'd20; in_y = 6'd22;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (add_x !== 6'd20 || op_count !== 8'd1) begin n_err++; $display("FAIL mid_pre got %0d/%0d exp 20/1", add_x, op_count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || add_x !== 6'd0 || op_count !== 8'd0) begin n_err++; $display("FAIL mid_rst got vld=%0b x=%0d cnt=%0d exp 0/0/0", out_valid, add_x, op_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rdy got %0b exp 1", in_ready); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_idle got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid); end
    in_valid = 1'b1; in_x = 6'd20; in_y = 6'd22;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 6'd42 || out_ov !== 1'b0 || op_count !== 8'd1) begin n_err++; $display("FAIL mid_after got vld=%0b s=%0d ov=%0b cnt=%0d exp 1/42/0/1", out_valid, out_s, out_ov, op_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
